// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: default widths, FSM state
// encoding and the full-adder cell used to build the trial subtractor.
package restoring_divider_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic cin);
    logic sum;
    logic cout;
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
    return {cout, sum};
  endfunction

endpackage

// File: rtl/restoring_divider_trial_subtract.sv
// Trial subtraction of the divisor from the shifted partial remainder.
// Ripple chain of full-adder cells computing minuend + ~{0,subtrahend} + 1;
// the final carry-out is high exactly when no borrow occurred.
module trial_subtract
  import restoring_divider_pkg::*;
#(
  parameter int W = DIVISOR_W
) (
  input  logic [W:0]   minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W:0]   difference,
  output logic         no_borrow
);

  logic [W:0] sub_ext_s;

  assign sub_ext_s = {1'b0, subtrahend};

  // Ripple the carry through W+1 full-adder cells with inverted subtrahend bits.
  always_comb begin
    logic       carry_s;
    logic [1:0] fa_s;
    carry_s    = 1'b1;
    fa_s       = 2'b00;
    difference = '0;
    for (int i = 0; i <= W; i++) begin
      fa_s          = full_adder(minuend[i], ~sub_ext_s[i], carry_s);
      difference[i] = fa_s[0];
      carry_s       = fa_s[1];
    end
    no_borrow = carry_s;
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock with a
// start/done handshake. Results are registered and held until the next
// completion; a divide by zero reports all-ones quotient and zero remainder.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int DIVIDEND_W = restoring_divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = restoring_divider_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int              CW         = $clog2(DIVIDEND_W + 1);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(DIVIDEND_W);

  logic [1:0]            state_r;
  logic [1:0]            next_state_s;
  logic [CW-1:0]         count_r;
  logic [DIVIDEND_W-1:0] shift_r;
  logic [DIVISOR_W:0]    p_r;
  logic [DIVISOR_W-1:0]  divisor_r;
  logic                  zero_r;
  logic                  accept_s;
  logic                  last_s;
  logic [DIVISOR_W:0]    shifted_s;
  logic [DIVISOR_W:0]    diff_s;
  logic                  no_borrow_s;
  logic                  busy_nxt_s;
  logic                  done_nxt_s;
  logic                  busy_r;
  logic                  done_r;
  logic [DIVIDEND_W-1:0] quotient_r;
  logic [DIVISOR_W-1:0]  remainder_r;
  logic                  dbz_r;

  assign accept_s  = start & (state_r != S_RUN);
  assign last_s    = (count_r == LAST_COUNT);
  assign shifted_s = {p_r[DIVISOR_W-1:0], shift_r[DIVIDEND_W-1]};

  trial_subtract #(.W(DIVISOR_W)) u_trial (
    .minuend    (shifted_s),
    .subtrahend (divisor_r),
    .difference (diff_s),
    .no_borrow  (no_borrow_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a zero divisor still passes through RUN for one cycle
  // (counter preset to its last value) so its completion lands one edge later.
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (accept_s) next_state_s = S_RUN;
        else          next_state_s = S_IDLE;
      end
      S_RUN: begin
        if (last_s) next_state_s = S_DONE;
        else        next_state_s = S_RUN;
      end
      S_DONE: begin
        if (accept_s) next_state_s = S_RUN;
        else          next_state_s = S_IDLE;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (next_state_s)
      S_RUN:   busy_nxt_s = 1'b1;
      S_DONE:  done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Operand capture and one restoring iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= '0;
      p_r       <= '0;
      divisor_r <= '0;
      zero_r    <= 1'b0;
      count_r   <= '0;
    end else if (accept_s) begin
      shift_r   <= dividend;
      p_r       <= '0;
      divisor_r <= divisor;
      zero_r    <= (divisor == '0);
      count_r   <= (divisor == '0) ? LAST_COUNT : '0;
    end else if ((state_r == S_RUN) && !last_s) begin
      p_r     <= no_borrow_s ? diff_s : shifted_s;
      shift_r <= {shift_r[DIVIDEND_W-2:0], no_borrow_s};
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      shift_r   <= shift_r;
      p_r       <= p_r;
      divisor_r <= divisor_r;
      zero_r    <= zero_r;
      count_r   <= count_r;
    end
  end

  // Result registers load only on the transition into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else if ((state_r == S_RUN) && last_s) begin
      if (zero_r) begin
        quotient_r  <= '1;
        remainder_r <= '0;
        dbz_r       <= 1'b1;
      end else begin
        quotient_r  <= shift_r;
        remainder_r <= p_r[DIVISOR_W-1:0];
        dbz_r       <= 1'b0;
      end
    end else begin
      quotient_r  <= quotient_r;
      remainder_r <= remainder_r;
      dbz_r       <= dbz_r;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vector table,
// handshake/reset sequences and a randomized sweep against an arithmetic model.
module tb_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int compared = 0;
  int mismatched = 0;

  restoring_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd;
    logic [3:0] dv;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Present a request for one cycle; accepted at the posedge inside (T0).
  task automatic issue(input logic [7:0] dd, input logic [3:0] dv);
    @(negedge clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = ~dd;          // later input changes must not matter
    divisor = dv + 4'd5;
  endtask

  // Count edges after acceptance until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 20);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int q_m, r_m;
    logic z_m;
    logic [7:0] dd;
    logic [3:0] dv;
    bit saw_done;

    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9};
    vecs[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9};
    vecs[2] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9};
    vecs[3] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 9};
    vecs[4] = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0, 9};
    vecs[5] = '{8'd77,  4'd0,  8'hFF,  4'd0, 1'b1, 1};
    vecs[6] = '{8'd9,   4'd2,  8'd4,   4'd1, 1'b0, 9};
    vecs[7] = '{8'd15,  4'd15, 8'd1,   4'd0, 1'b0, 9};

    do_reset();
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quot", quotient, 0);
    check("reset_rem", remainder, 0);
    check("reset_dbz", div_by_zero, 0);

    // Directed vector table.
    foreach (vecs[i]) begin
      issue(vecs[i].dd, vecs[i].dv);
      if (vecs[i].dv != 4'd0) check("vec_busy", busy, 1);
      else check("vec_dbz_no_done_yet", done, 0);
      wait_done(cyc);
      check("vec_latency", cyc, vecs[i].cyc);
      check("vec_quot", quotient, vecs[i].q);
      check("vec_rem", remainder, vecs[i].r);
      check("vec_dbz", div_by_zero, vecs[i].z);
      @(posedge clk);
      #1;
      check("vec_done_pulse", done, 0);
      check("vec_idle_busy", busy, 0);
    end

    // Start while busy is ignored.
    issue(8'd200, 4'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("busy_ign_done_seen", done, 1);
    check("busy_ign_quot", quotient, 28);
    check("busy_ign_rem", remainder, 4);
    @(posedge clk);
    #1;
    check("busy_ign_no_requeue", busy, 0);

    // Back-to-back: start asserted during the DONE cycle.
    issue(8'd200, 4'd7);
    wait_done(cyc);
    check("b2b_first_quot", quotient, 28);
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_held_quot", quotient, 28);
    wait_done(cyc);
    check("b2b_latency", cyc, 9);
    check("b2b_quot", quotient, 33);
    check("b2b_rem", remainder, 1);

    // Reset in the middle of an iteration sequence.
    issue(8'd200, 4'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quot", quotient, 0);
    check("midrst_rem", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    issue(8'd9, 4'd2);
    wait_done(cyc);
    check("post_rst_quot", quotient, 4);
    check("post_rst_rem", remainder, 1);

    // Randomized sweep against an arithmetic model.
    for (int n = 0; n < 60; n++) begin
      dd = 8'($urandom_range(0, 255));
      dv = 4'($urandom_range(0, 15));
      if (dv == 4'd0) begin
        q_m = 255; r_m = 0; z_m = 1'b1;
      end else begin
        q_m = int'(dd) / int'(dv);
        r_m = int'(dd) % int'(dv);
        z_m = 1'b0;
      end
      issue(dd, dv);
      wait_done(cyc);
      check("rnd_latency", cyc, (dv == 4'd0) ? 1 : 9);
      check("rnd_quot", quotient, q_m);
      check("rnd_rem", remainder, r_m);
      check("rnd_dbz", div_by_zero, z_m);
      if (dv != 4'd0) begin
        check("rnd_inv_rem_lt", (int'(remainder) < int'(dv)) ? 1 : 0, 1);
        check("rnd_inv_recon", int'(quotient) * int'(dv) + int'(remainder), int'(dd));
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
